seq_bam_mult: RTL



---
 rtl/seq_bam_mult.sv | 128 ++++++++++++
 1 files changed

// File: rtl/seq_bam_mult.sv
// Sequential broken-array multiplier: accumulates one kept partial-product
// row per clock, with per-operation horizontal/vertical break levels.
module seq_bam_mult #(
   parameter int N  = 8,
   parameter int HW = $clog2(N + 1),
   parameter int VW = $clog2(2 * N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N-1:0]    a,
   input  logic [N-1:0]    b,
   input  logic [HW-1:0]   cfg_h,
   input  logic [VW-1:0]   cfg_v,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2*N-1:0]  p,
   output logic            busy
);

   localparam int JW = (N > 2) ? $clog2(N) : 1;
   localparam int SW = VW + 1;
   localparam logic [HW-1:0] NH    = HW'(N);
   localparam logic [JW-1:0] JLAST = JW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     a_q, b_q;
   logic [VW-1:0]    cfgv_q;
   logic [JW-1:0]    j_q;
   logic [2*N-1:0]   acc_q, p_q;
   logic [N-1:0]     mask;
   logic [2*N-1:0]   row, acc_nxt;
   logic             accept, skip, last;

   assign accept = (state_q == IDLE) && in_valid;
   assign skip   = (cfg_h >= NH);
   assign last   = (j_q == JLAST);

   // Keep term i of row j only when i + j reaches the vertical break.
   always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++) begin
         mask[i] = (SW'(i) + SW'(j_q)) >= SW'(cfgv_q);
      end
   end

   always_comb begin
      row = '0;
      if (b_q[j_q]) begin
         row = {{N{1'b0}}, a_q & mask} << j_q;
      end
   end

   assign acc_nxt = acc_q + row;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = skip ? DONE : RUN;
            end
         end
         RUN: begin
            if (last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q == RUN) || (state_q == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         cfgv_q <= '0;
         j_q    <= '0;
         acc_q  <= '0;
         p_q    <= '0;
      end else if (accept) begin
         a_q    <= a;
         b_q    <= b;
         cfgv_q <= cfg_v;
         acc_q  <= '0;
         if (skip) begin
            p_q <= '0;
         end else begin
            j_q <= cfg_h[JW-1:0];
         end
      end else if (state_q == RUN) begin
         acc_q <= acc_nxt;
         j_q   <= j_q + 1'b1;
         if (last) begin
            p_q <= acc_nxt;
         end
      end
   end

   assign p = p_q;

endmodule
